toggle_burst_gen: RTL and testbench

TOGGLE_BURST_GEN -- requirements
Module: toggle_burst_gen

---
 rtl/toggle_burst_pkg.sv | 12 +
 rtl/period_down_counter.sv | 21 ++
 rtl/toggle_burst_gen.sv | 95 +++++++++
 tb/tb_toggle_burst_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/toggle_burst_pkg.sv
// Shared definitions for the toggle burst generator: state encoding and default widths.
package toggle_burst_pkg;
  localparam int CNT_W_DEF = 8;
  localparam int PER_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/period_down_counter.sv
// Loadable saturating down-counter; times the gap between toggle pulses.
module period_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                    cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/toggle_burst_gen.sv
// Emits burst_len one-cycle T pulses spaced period cycles apart, with abort and done.
module toggle_burst_gen
  import toggle_burst_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PER_W = PER_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [PER_W-1:0] period,
  input  logic             abort,
  output logic             T,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_left
);
  state_e           state, nxt;
  logic [CNT_W-1:0] pl_q;
  logic [PER_W-1:0] per_q;
  logic             accept, gap_zero, gap_load;
  logic             t_nxt, busy_nxt, done_nxt;
  logic             t_q, busy_q, done_q;

  assign accept   = (state == S_IDLE) && start && !abort;
  assign gap_load = (state == S_PULSE) && (nxt == S_GAP);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (accept) nxt = (burst_len == '0) ? S_DONE : S_PULSE;
      S_PULSE: begin
        if (abort)                    nxt = S_IDLE;
        else if (pl_q <= CNT_W'(1))   nxt = S_DONE;
        else if (per_q > PER_W'(1))   nxt = S_GAP;
        else                          nxt = S_PULSE;
      end
      S_GAP:   begin
        if (abort)         nxt = S_IDLE;
        else if (gap_zero) nxt = S_PULSE;
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and then registered, so they are
  // valid in the same cycle as the state they describe and never glitch.
  always_comb begin
    t_nxt    = (nxt == S_PULSE);
    done_nxt = (nxt == S_DONE);
    busy_nxt = (nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pl_q   <= '0;
      per_q  <= '0;
    end else begin
      t_q    <= t_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      if (accept) begin
        pl_q  <= burst_len;
        per_q <= (period == '0) ? PER_W'(1) : period;
      end else if (state == S_PULSE && !abort && pl_q != '0) begin
        pl_q <= pl_q - CNT_W'(1);
      end
    end
  end

  // Gap spans period-1 cycles: loaded with period-2, the last gap cycle sees zero.
  period_down_counter #(.W(PER_W)) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (per_q - PER_W'(2)),
    .en       (state == S_GAP),
    .zero     (gap_zero)
  );

  assign T           = t_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pulses_left = pl_q;
endmodule

// File: tb/tb_toggle_burst_gen.sv
// Randomized bench for toggle_burst_gen against a schedule-based reference model.
module tb_toggle_burst_gen;
  localparam int CW = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [CW-1:0] burst_len, pulses_left;
  logic [PW-1:0] period;
  logic          T, busy, done;

  always #5 clk = ~clk;

  toggle_burst_gen #(.CNT_W(CW), .PER_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .period(period),
    .abort(abort), .T(T), .busy(busy), .done(done), .pulses_left(pulses_left)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: a burst accepted in cycle acc pulses at acc+1+k*per, k<len, then done.
  bit m_act = 0;
  int m_acc = 0, m_len = 0, m_per = 1, m_pl = 0, cyc = 0;

  task automatic model_out(input int c, output bit et, output bit eb, output bit ed,
                           output int epl);
    int rel, drel, cnt;
    if (!m_act) begin
      et = 0; eb = 0; ed = 0; epl = m_pl;
    end else begin
      rel  = c - m_acc;
      drel = (m_len == 0) ? 1 : (m_len - 1) * m_per + 2;
      et   = (m_len != 0) && ((rel - 1) % m_per == 0) && ((rel - 1) / m_per < m_len);
      ed   = (rel == drel);
      eb   = 1;
      cnt  = (rel - 1 + m_per - 1) / m_per;
      if (cnt > m_len) cnt = m_len;
      epl  = m_len - cnt;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    bit ct, cb, cd, et, eb, ed;
    int cpl, epl;
    model_out(cyc, ct, cb, cd, cpl);
    @(posedge clk);
    if (rst) begin
      m_act = 0; m_pl = 0;
    end else if (!m_act) begin
      if (start && !abort) begin
        m_act = 1; m_acc = cyc; m_len = int'(burst_len);
        m_per = (period == 0) ? 1 : int'(period);
        m_pl  = int'(burst_len);
      end
    end else if (cd) begin
      m_act = 0; m_pl = 0;
    end else if (abort) begin
      m_act = 0; m_pl = cpl;
    end
    cyc++;
    #1;
    model_out(cyc, et, eb, ed, epl);
    n_tests++;
    if (T !== et || busy !== eb || done !== ed || int'(pulses_left) != epl) begin
      n_fail++;
      $display("FAIL model cyc=%0d: T/busy/done/pl got %b%b%b/%0d, expected %b%b%b/%0d",
               cyc, T, busy, done, pulses_left, et, eb, ed, epl);
    end
  endtask

  task automatic run_burst(input int len, input int per, input int n, input bit noise,
                           output logic [15:0] tv, output logic [15:0] dv,
                           output logic [15:0] bv);
    tv = '0; dv = '0; bv = '0;
    burst_len = CW'(len); period = PW'(per); start = 1'b1;
    step();
    tv[1] = T; dv[1] = done; bv[1] = busy;
    for (int i = 2; i <= n; i++) begin
      if (noise) begin
        start = 1'b1; burst_len = CW'(9); period = PW'($urandom_range(0, 7));
      end else begin
        start = 1'b0;
      end
      step();
      tv[i] = T; dv[i] = done; bv[i] = busy;
    end
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] tv, dv, bv;
    bit seen_done;
    rst = 1'b1; start = 1'b0; abort = 1'b0; burst_len = '0; period = '0;
    step(); step();
    chk("reset_outputs", int'({T, busy, done}), 0);
    chk("reset_pl", int'(pulses_left), 0);
    rst = 1'b0;
    step();

    run_burst(3, 4, 11, 0, tv, dv, bv);
    chk("len3_per4_T", int'(tv), 16'h0222);
    chk("len3_per4_done", int'(dv), 16'h0400);
    chk("len3_per4_busy", int'(bv), 16'h07FE);
    step();

    run_burst(4, 0, 6, 0, tv, dv, bv);
    chk("per0_T", int'(tv), 16'h001E);
    chk("per0_done", int'(dv), 16'h0020);
    chk("per0_busy", int'(bv), 16'h003E);
    step();

    run_burst(0, 5, 3, 0, tv, dv, bv);
    chk("len0_T", int'(tv), 0);
    chk("len0_done", int'(dv), 16'h0002);
    chk("len0_busy", int'(bv), 16'h0002);
    step();

    burst_len = CW'(5); period = PW'(3); start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("abort_pre_pl", int'(pulses_left), 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_pl", int'(pulses_left), 3);
    seen_done = 0;
    repeat (8) begin step(); seen_done |= done; end
    chk("abort_no_done", int'(seen_done), 0);

    burst_len = CW'(2); period = PW'(3); start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_outputs", int'({T, busy, done, pulses_left}), 0);
    run_burst(3, 4, 11, 0, tv, dv, bv);
    chk("postrst_T", int'(tv), 16'h0222);
    chk("postrst_done", int'(dv), 16'h0400);
    step();

    run_burst(3, 2, 7, 1, tv, dv, bv);
    chk("restart_T", int'(tv), 16'h002A);
    chk("restart_done", int'(dv), 16'h0040);
    chk("restart_busy", int'(bv), 16'h007E);
    step();

    for (int i = 0; i < 4000; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      burst_len = ($urandom_range(0, 15) == 0) ? CW'($urandom_range(0, 40))
                                               : CW'($urandom_range(0, 5));
      period    = ($urandom_range(0, 9) == 0) ? PW'($urandom_range(0, 255))
                                              : PW'($urandom_range(0, 4));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
